// File: rtl/reaction_game_pkg.sv
// Shared types and helpers for the keypad reaction game controller.
package reaction_game_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSpin     = 3'd1,
    StWaitKey  = 3'd2,
    StShowHit  = 3'd3,
    StShowMiss = 3'd4,
    StGameOver = 3'd5
  } game_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BcdMax = 16'h9999;

  // Right-shifting Galois feedback masks for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return (32'h1 << (w - 1)) | 32'h1;
    endcase
  endfunction

  function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    bcd_digit_t  d;
    if (v == BcdMax) return v;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = r[i*4 +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Valid BCD orders digit-by-digit the same way as plain unsigned binary.
  function automatic logic bcd_lt(input logic [15:0] a, input logic [15:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear that saturates at 9999.
module bcd_counter4
  import reaction_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en && inc) begin
      value_d = bcd_inc4(value_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction game controller: spins and freezes a random target, times the player
// in BCD ticks and keeps tries, score and best time across the rounds of a game.
module reaction_game_ctrl
  import reaction_game_pkg::*;
#(
  parameter int unsigned       NUM_KEYS  = 8,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned       TICK_DIV  = 100000,
  parameter int unsigned       MAX_TRIES = 3,
  parameter int unsigned       ROUNDS    = 5,
  parameter int unsigned       FB_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [NUM_KEYS-1:0] keypad,
  output logic [3:0]          target,
  output logic                spinning,
  output logic [15:0]         timer_bcd,
  output logic                hit_pulse,
  output logic                miss_pulse,
  output logic [2:0]          tries_left,
  output logic [3:0]          score,
  output logic [15:0]         best_bcd,
  output logic [2:0]          game_state
);

  localparam int unsigned       K      = $clog2(NUM_KEYS + 1);
  localparam int unsigned       PrescW = $clog2(TICK_DIV);
  localparam int unsigned       FbW    = $clog2(FB_CYCLES + 1);
  localparam logic [LFSR_W-1:0] Taps   = LFSR_W'(lfsr_taps(LFSR_W));

  game_state_e         state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                start_sync_q, start_prev_q, stop_sync_q, stop_prev_q;
  logic [NUM_KEYS-1:0] key_sync_q, key_prev_q;
  logic [3:0]          target_q, target_d, score_q, score_d, round_q, round_d;
  logic [2:0]          tries_q, tries_d;
  logic [15:0]         best_q, best_d, timer_val;
  logic [FbW-1:0]      fb_q, fb_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic                hit_q, hit_d, miss_q, miss_d;
  logic                start_edge, stop_edge, key_valid, key_match, stop_accept;
  logic                timer_run, presc_last;
  logic [NUM_KEYS-1:0] key_rise, target_mask;
  logic [3:0]          cand;

  assign start_edge  = start_sync_q & ~start_prev_q;
  assign stop_edge   = stop_sync_q & ~stop_prev_q;
  assign key_rise    = key_sync_q & ~key_prev_q;
  assign key_valid   = $onehot(key_rise);
  assign target_mask = NUM_KEYS'(1) << (target_q - 4'd1);
  assign key_match   = (key_rise == target_mask);
  assign cand        = 4'(lfsr_q[K-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lfsr_q       <= LFSR_SEED;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      stop_sync_q  <= 1'b0;
      stop_prev_q  <= 1'b0;
      key_sync_q   <= '0;
      key_prev_q   <= '0;
      target_q     <= '0;
      tries_q      <= '0;
      score_q      <= '0;
      round_q      <= '0;
      best_q       <= BcdMax;
      fb_q         <= '0;
      presc_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : '0);
      start_sync_q <= start;
      start_prev_q <= start_sync_q;
      stop_sync_q  <= stop;
      stop_prev_q  <= stop_sync_q;
      key_sync_q   <= keypad;
      key_prev_q   <= key_sync_q;
      target_q     <= target_d;
      tries_q      <= tries_d;
      score_q      <= score_d;
      round_q      <= round_d;
      best_q       <= best_d;
      fb_q         <= fb_d;
      presc_q      <= presc_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    tries_d     = tries_q;
    score_d     = score_q;
    round_d     = round_q;
    best_d      = best_q;
    fb_d        = fb_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    stop_accept = 1'b0;
    if (start_edge) begin
      state_d = StSpin;
      score_d = '0;
      best_d  = BcdMax;
      round_d = '0;
    end else begin
      case (state_q)
        StSpin: begin
          if (stop_edge) begin
            stop_accept = 1'b1;
            state_d     = StWaitKey;
            tries_d     = 3'(MAX_TRIES);
            if (target_q == 4'd0) target_d = 4'd1;
          end
        end
        StWaitKey: begin
          if (key_valid && key_match) begin
            hit_d   = 1'b1;
            state_d = StShowHit;
            fb_d    = '0;
            if (score_q != 4'd15) score_d = score_q + 4'd1;
            if (bcd_lt(timer_val, best_q)) best_d = timer_val;
          end else if (key_valid) begin
            miss_d  = 1'b1;
            tries_d = tries_q - 3'd1;
            if (tries_q == 3'd1) begin
              state_d = StShowMiss;
              fb_d    = '0;
            end
          end
        end
        StShowHit, StShowMiss: begin
          if (fb_q == FbW'(FB_CYCLES - 1)) begin
            round_d = round_q + 4'd1;
            state_d = (round_d == 4'(ROUNDS)) ? StGameOver : StSpin;
          end else begin
            fb_d = fb_q + FbW'(1);
          end
        end
        StIdle, StGameOver: ;
        default: state_d = StIdle;
      endcase
    end
    // Target keeps spinning on a start edge seen in SPIN; only an accepted stop freezes it.
    if (state_q == StSpin && !stop_accept && cand != 4'd0 && cand <= 4'(NUM_KEYS)) begin
      target_d = cand;
    end
  end

  // Timer freezes on the cycle a key ends the round, so best matches the display.
  assign timer_run  = (state_q == StWaitKey) && (state_d == StWaitKey);
  assign presc_last = (presc_q == PrescW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (stop_accept) begin
      presc_d = '0;
    end else if (timer_run) begin
      presc_d = presc_last ? '0 : presc_q + PrescW'(1);
    end
  end

  bcd_counter4 u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (stop_accept),
    .en    (timer_run),
    .inc   (presc_last),
    .value (timer_val)
  );

  always_comb begin
    target     = target_q;
    spinning   = (state_q == StSpin);
    timer_bcd  = timer_val;
    hit_pulse  = hit_q;
    miss_pulse = miss_q;
    tries_left = tries_q;
    score      = score_q;
    best_bcd   = best_q;
    game_state = state_q;
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with a small LFSR/target model for key selection.
module tb_reaction_game_ctrl;

  localparam logic [15:0] Seed = 16'hACE1;
  localparam logic [2:0]  SIdle = 3'd0, SSpin = 3'd1, SWait = 3'd2;
  localparam logic [2:0]  SHit = 3'd3, SMiss = 3'd4, SOver = 3'd5;

  logic        clk, rst, start, stop;
  logic [7:0]  keypad;
  logic [3:0]  target, score;
  logic        spinning, hit_pulse, miss_pulse;
  logic [15:0] timer_bcd, best_bcd;
  logic [2:0]  tries_left, game_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int unsigned cycles;
    logic [15:0] timer;
  } tvec_t;
  tvec_t tv[9];

  logic [15:0] m_lfsr;
  logic [3:0]  m_tgt;
  logic        m_spin = 1'b0;
  logic [3:0]  tgt;
  logic [3:0]  wrong;

  reaction_game_ctrl #(
    .NUM_KEYS  (8),
    .LFSR_W    (16),
    .LFSR_SEED (Seed),
    .TICK_DIV  (4),
    .MAX_TRIES (3),
    .ROUNDS    (2),
    .FB_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .keypad     (keypad),
    .target     (target),
    .spinning   (spinning),
    .timer_bcd  (timer_bcd),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .tries_left (tries_left),
    .score      (score),
    .best_bcd   (best_bcd),
    .game_state (game_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR and spinning target; m_spin marks edges where SPIN should sample.
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= Seed;
      m_tgt  <= 4'd0;
    end else begin
      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (m_spin && m_lfsr[3:0] != 4'd0 && m_lfsr[3:0] <= 4'd8) m_tgt <= m_lfsr[3:0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] key_mask(input logic [3:0] k);
    return 8'(1) << (k - 4'd1);
  endfunction

  // Raise stop, let it be accepted, and return the frozen target the model predicts.
  task automatic do_stop(output logic [3:0] t);
    stop = 1'b1;
    step();
    m_spin = 1'b0;
    step();
    stop = 1'b0;
    t = (m_tgt == 4'd0) ? 4'd1 : m_tgt;
    check("stop_state", 16'(game_state), 16'(SWait));
    check("stop_target", 16'(target), 16'(t));
    check("stop_tries", 16'(tries_left), 16'd3);
    check("stop_timer", timer_bcd, 16'h0000);
  endtask

  task automatic do_start();
    start = 1'b1;
    steps(2);
    m_spin = 1'b1;
    start = 1'b0;
    check("start_state", 16'(game_state), 16'(SSpin));
    check("start_spinning", 16'(spinning), 16'd1);
    check("start_score", 16'(score), 16'd0);
    check("start_best", best_bcd, 16'h9999);
  endtask

  initial begin
    tv[0] = '{3, 16'h0000};
    tv[1] = '{1, 16'h0001};
    tv[2] = '{3992, 16'h0999};
    tv[3] = '{3, 16'h0999};
    tv[4] = '{1, 16'h1000};
    tv[5] = '{36, 16'h1009};
    tv[6] = '{4, 16'h1010};
    tv[7] = '{35956, 16'h9999};
    tv[8] = '{100, 16'h9999};

    rst = 1'b1; start = 1'b0; stop = 1'b0; keypad = 8'h00;
    steps(2);
    check("rst_target", 16'(target), 16'd0);
    check("rst_best", best_bcd, 16'h9999);
    check("rst_state", 16'(game_state), 16'(SIdle));
    check("rst_lfsr", dut.lfsr_q, Seed);
    check("rst_tries", 16'(tries_left), 16'd0);
    check("rst_score", 16'(score), 16'd0);
    check("rst_timer", timer_bcd, 16'h0000);
    check("rst_spinning", 16'(spinning), 16'd0);
    rst = 1'b0;
    steps(5);
    check("idle_state", 16'(game_state), 16'(SIdle));
    check("lfsr_advance", dut.lfsr_q, m_lfsr);

    // Game 1, round 1: two-key press then miss exhaustion.
    do_start();
    steps(20);
    check("spin_target", 16'(target), 16'(m_tgt));
    do_stop(tgt);
    wrong = (tgt == 4'd1) ? 4'd2 : 4'd1;
    keypad = 8'h03;
    steps(2);
    check("two_key_miss", 16'(miss_pulse), 16'd0);
    check("two_key_hit", 16'(hit_pulse), 16'd0);
    check("two_key_tries", 16'(tries_left), 16'd3);
    step();
    keypad = 8'h00;
    step();
    for (int i = 0; i < 3; i++) begin
      keypad = key_mask(wrong);
      steps(2);
      check("miss_pulse", 16'(miss_pulse), 16'd1);
      check("miss_no_hit", 16'(hit_pulse), 16'd0);
      check("miss_tries", 16'(tries_left), 16'(2 - i));
      step();
      check("miss_width", 16'(miss_pulse), 16'd0);
      keypad = 8'h00;
      step();
    end
    check("show_miss_state", 16'(game_state), 16'(SMiss));
    step();
    check("miss_to_spin", 16'(game_state), 16'(SSpin));
    m_spin = 1'b1;

    // Game 1, round 2: timed hit, then game over.
    steps(20);
    do_stop(tgt);
    steps(39);
    keypad = key_mask(tgt);
    steps(2);
    check("hit_pulse", 16'(hit_pulse), 16'd1);
    check("hit_timer", timer_bcd, 16'h0010);
    check("hit_score", 16'(score), 16'd1);
    check("hit_best", best_bcd, 16'h0010);
    check("hit_state", 16'(game_state), 16'(SHit));
    step();
    check("hit_width", 16'(hit_pulse), 16'd0);
    check("hit_timer_frozen", timer_bcd, 16'h0010);
    keypad = 8'h00;
    step();
    check("show_hit_hold", 16'(game_state), 16'(SHit));
    step();
    check("over_state", 16'(game_state), 16'(SOver));
    steps(10);
    check("over_hold_state", 16'(game_state), 16'(SOver));
    check("over_score", 16'(score), 16'd1);
    check("over_best", best_bcd, 16'h0010);
    check("over_target", 16'(target), 16'(tgt));

    // Game 2: immediate hit, then timer sweep to saturation and abort.
    do_start();
    steps(20);
    do_stop(tgt);
    keypad = key_mask(tgt);
    steps(2);
    check("fast_hit", 16'(hit_pulse), 16'd1);
    check("fast_timer", timer_bcd, 16'h0000);
    check("fast_best", best_bcd, 16'h0000);
    step();
    keypad = 8'h00;
    steps(2);
    check("fast_to_spin", 16'(game_state), 16'(SSpin));
    m_spin = 1'b1;
    steps(20);
    do_stop(tgt);
    for (int i = 0; i < 9; i++) begin
      steps(tv[i].cycles);
      check($sformatf("timer_vec%0d", i), timer_bcd, tv[i].timer);
    end
    check("sat_state", 16'(game_state), 16'(SWait));
    start = 1'b1;
    steps(2);
    m_spin = 1'b1;
    start = 1'b0;
    check("abort_state", 16'(game_state), 16'(SSpin));
    check("abort_score", 16'(score), 16'd0);
    check("abort_best", best_bcd, 16'h9999);
    steps(3);
    start = 1'b1;
    stop = 1'b1;
    steps(2);
    start = 1'b0;
    stop = 1'b0;
    check("start_beats_stop", 16'(game_state), 16'(SSpin));
    step();
    check("still_spin", 16'(game_state), 16'(SSpin));
    check("still_spin_target", 16'(target), 16'(m_tgt));

    // Reset in the middle of a round.
    steps(5);
    do_stop(tgt);
    steps(9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_spin = 1'b0;
    check("midrst_state", 16'(game_state), 16'(SIdle));
    check("midrst_target", 16'(target), 16'd0);
    check("midrst_timer", timer_bcd, 16'h0000);
    check("midrst_tries", 16'(tries_left), 16'd0);
    check("midrst_best", best_bcd, 16'h9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
